// File: rtl/bar_builder.sv
// Frame bar builder: reads N magnitude bins, converts them to saturated bar
// heights with per-bin peak-hold decay, and streams the heights to the bar RAM.
module bar_builder #(
  parameter int unsigned N     = 256,
  parameter int unsigned MAG_W = 14,
  parameter int unsigned BAR_W = 9,
  parameter int unsigned SHIFT = 5,
  parameter int unsigned MAX_H = 480,
  parameter int unsigned DECAY = 4
) (
  input  logic                 clk_50MHz,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 mag_rd,
  output logic [$clog2(N)-1:0] mag_addr,
  input  logic [MAG_W-1:0]     mag_data,
  output logic                 bar_wr,
  output logic [$clog2(N)-1:0] bar_addr,
  output logic [BAR_W-1:0]     bar_data
);

  localparam int unsigned AW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_busy;
  logic              r_done;
  logic              r_mag_rd;
  logic [AW-1:0]     r_mag_addr;
  logic              r_bar_wr;
  logic [AW-1:0]     r_bar_addr;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_mag_rd_nxt;
  logic [AW-1:0]     w_mag_addr_nxt;
  logic              w_bar_wr_nxt;
  logic [AW-1:0]     w_bar_addr_nxt;

  logic [BAR_W-1:0]  r_held [N];
  logic [MAG_W-1:0]  w_shifted;
  logic [BAR_W-1:0]  w_clip;
  logic [BAR_W-1:0]  w_held;
  logic [BAR_W-1:0]  w_decayed;
  logic [BAR_W-1:0]  w_new;

  // State and registered outputs
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mag_rd   <= 1'b0;
      r_mag_addr <= '0;
      r_bar_wr   <= 1'b0;
      r_bar_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_mag_rd   <= w_mag_rd_nxt;
      r_mag_addr <= w_mag_addr_nxt;
      r_bar_wr   <= w_bar_wr_nxt;
      r_bar_addr <= w_bar_addr_nxt;
    end
  end

  // Next state; mag_addr doubles as the read counter and stops at N-1
  always_comb begin
    w_state_nxt    = r_state;
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    w_mag_rd_nxt   = 1'b0;
    w_mag_addr_nxt = r_mag_addr;
    w_bar_wr_nxt   = 1'b0;
    w_bar_addr_nxt = r_bar_addr;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt    = S_RUN;
          w_busy_nxt     = 1'b1;
          w_mag_rd_nxt   = 1'b1;
          w_mag_addr_nxt = '0;
        end
      end
      S_RUN: begin
        w_busy_nxt     = 1'b1;
        w_bar_wr_nxt   = 1'b1;
        w_bar_addr_nxt = r_mag_addr;
        if (r_mag_addr == AW'(N - 1)) begin
          w_state_nxt = S_FLUSH;
        end else begin
          w_mag_rd_nxt   = 1'b1;
          w_mag_addr_nxt = r_mag_addr + AW'(1);
        end
      end
      S_FLUSH: begin
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Height arithmetic works on the store output in the same cycle it is valid
  always_comb begin
    w_shifted = mag_data >> SHIFT;
    w_clip    = (32'(w_shifted) > MAX_H) ? BAR_W'(MAX_H) : BAR_W'(w_shifted);
    w_held    = r_held[r_bar_addr];
    w_decayed = (32'(w_held) > DECAY) ? (w_held - BAR_W'(DECAY)) : '0;
    w_new     = (w_clip > w_decayed) ? w_clip : w_decayed;
  end

  // Peak-hold memory, updated alongside each bar write
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        r_held[i] <= '0;
      end
    end else if (r_bar_wr) begin
      r_held[r_bar_addr] <= w_new;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign mag_rd   = r_mag_rd;
  assign mag_addr = r_mag_addr;
  assign bar_wr   = r_bar_wr;
  assign bar_addr = r_bar_addr;
  assign bar_data = r_bar_wr ? w_new : '0;

endmodule

// File: tb/tb_bar_builder.sv
// Bench for bar_builder: randomized and directed frames checked cycle by cycle
// against a per-bin peak-hold reference model.
module tb_bar_builder;

  localparam int unsigned N     = 256;
  localparam int unsigned MAG_W = 14;
  localparam int unsigned BAR_W = 9;
  localparam int unsigned SHIFT = 5;
  localparam int unsigned MAX_H = 480;
  localparam int unsigned DECAY = 4;
  localparam int unsigned AW    = $clog2(N);

  logic             clk_50MHz = 1'b0;
  logic             rst       = 1'b0;
  logic             start     = 1'b0;
  logic             busy;
  logic             done;
  logic             mag_rd;
  logic [AW-1:0]    mag_addr;
  logic [MAG_W-1:0] mag_data = '0;
  logic             bar_wr;
  logic [AW-1:0]    bar_addr;
  logic [BAR_W-1:0] bar_data;

  logic [MAG_W-1:0] mem [N];
  int               ref_held [N];
  int               n_checks = 0;
  int               n_errors = 0;

  bar_builder #(
    .N(N), .MAG_W(MAG_W), .BAR_W(BAR_W), .SHIFT(SHIFT), .MAX_H(MAX_H), .DECAY(DECAY)
  ) dut (
    .clk_50MHz(clk_50MHz),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .mag_rd   (mag_rd),
    .mag_addr (mag_addr),
    .mag_data (mag_data),
    .bar_wr   (bar_wr),
    .bar_addr (bar_addr),
    .bar_data (bar_data)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  // Synchronous-read magnitude store
  always @(posedge clk_50MHz) begin
    if (mag_rd) mag_data <= mem[mag_addr];
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_height(input int mag, input int held);
    int s, h, d;
    s = mag / (1 << SHIFT);
    h = (s > int'(MAX_H)) ? int'(MAX_H) : s;
    d = (held > int'(DECAY)) ? held - int'(DECAY) : 0;
    return (h > d) ? h : d;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, int'({busy, done, mag_rd, bar_wr}), 0);
    check({tag, "_mag_addr"}, int'(mag_addr), 0);
    check({tag, "_bar_addr"}, int'(bar_addr), 0);
    check({tag, "_bar_data"}, int'(bar_data), 0);
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < int'(N); i++) mem[i] = MAG_W'(v);
  endtask

  task automatic fill_random();
    for (int i = 0; i < int'(N); i++) begin
      if ($urandom_range(0, 3) == 0) mem[i] = '0;
      else mem[i] = MAG_W'($urandom_range(0, (1 << MAG_W) - 1));
    end
  endtask

  // One frame: start held start_len cycles, extra start pulses at x1/x2,
  // optional reset at cycle abort_at (negative disables).
  task automatic run_frame(input int start_len, input int x1, input int x2, input int abort_at);
    int n_wr, n_done, k, e;
    logic eb, ed, er, ew;
    n_wr   = 0;
    n_done = 0;
    @(negedge clk_50MHz);
    start = 1'b1;
    for (int c = 1; c <= int'(N) + 3; c++) begin
      @(negedge clk_50MHz);
      start = (c < start_len) || (c == x1) || (c == x2);
      if (c == abort_at) begin
        rst = 1'b0;
        start = 1'b0;
        #1;
        check_all_zero("abort");
        for (int i = 0; i < int'(N); i++) ref_held[i] = 0;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk_50MHz);
          check("abort_hold_ctrl", int'({busy, done, mag_rd, bar_wr}), 0);
        end
        rst = 1'b1;
        return;
      end
      eb = (c <= int'(N) + 2);
      ed = (c == int'(N) + 2);
      er = (c <= int'(N));
      ew = (c >= 2) && (c <= int'(N) + 1);
      check($sformatf("ctrl_c%0d", c), int'({busy, done, mag_rd, bar_wr}), int'({eb, ed, er, ew}));
      if (er) check($sformatf("mag_addr_c%0d", c), int'(mag_addr), c - 1);
      if (ew) begin
        k = c - 2;
        e = ref_height(int'(mem[k]), ref_held[k]);
        check($sformatf("bar_addr_c%0d", c), int'(bar_addr), k);
        check($sformatf("bar_data_k%0d", k), int'(bar_data), e);
        ref_held[k] = e;
      end
      n_wr   += int'(bar_wr);
      n_done += int'(done);
    end
    check("frame_writes", n_wr, int'(N));
    check("frame_dones", n_done, 1);
  endtask

  initial begin
    for (int i = 0; i < int'(N); i++) begin
      ref_held[i] = 0;
      mem[i] = '0;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk_50MHz);
    check_all_zero("reset");
    rst = 1'b1;

    for (int c = 0; c < 100; c++) begin
      @(negedge clk_50MHz);
      check("idle_ctrl", int'({busy, done, mag_rd, bar_wr}), 0);
    end

    fill_const(16'h0400);
    run_frame(1, -1, -1, -1);

    // Saturated peak on bin 7, then decay to the floor
    fill_const(0);
    mem[7] = 14'h3FFF;
    run_frame(1, -1, -1, -1);
    fill_const(0);
    repeat (122) run_frame(1, -1, -1, -1);

    // New peak overrides decay; small bar decays to zero
    mem[7] = 14'h3FFF;
    mem[3] = MAG_W'(2 << SHIFT);
    run_frame(1, -1, -1, -1);
    fill_const(0);
    mem[7] = MAG_W'(478 << SHIFT);
    run_frame(1, -1, -1, -1);

    repeat (4) begin
      fill_random();
      run_frame(1, -1, -1, -1);
    end

    // Stray and stretched starts while busy
    fill_random();
    run_frame(3, 50, int'(N) + 2, -1);

    // Reset mid-frame, then verify cleared history
    fill_const(16'h3000);
    run_frame(1, -1, -1, -1);
    fill_random();
    run_frame(1, -1, -1, 100);
    fill_const(0);
    run_frame(1, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
